// File: rtl/freq_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Holds the run-state encoding and the smallest divisor the counter supports.
package freq_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int MIN_DIV = 2;

endpackage

// File: rtl/div_ratio_shadow.sv
// Divisor shadow register: holds a requested divisor until the next period boundary.
// Also owns the in-effect divisor and flags illegal requests.
module div_ratio_shadow
   import freq_div_pkg::*;
#(
   parameter int DIV_W     = 8,
   parameter int DIV_RESET = 6
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_val,
   input  logic             apply,
   output logic [DIV_W-1:0] cur_div,
   output logic             div_err
);

   logic [DIV_W-1:0] pending;
   logic             pend_valid;
   logic             legal;
   logic             load_ok;

   assign legal   = (div_val >= DIV_W'(MIN_DIV));
   assign load_ok = div_load & legal;

   // A load coinciding with apply wins over an older pending value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending    <= '0;
         pend_valid <= 1'b0;
         cur_div    <= DIV_W'(DIV_RESET);
         div_err    <= 1'b0;
      end else begin
         div_err <= div_load & ~legal;
         if (apply) begin
            if (load_ok) begin
               cur_div <= div_val;
            end else if (pend_valid) begin
               cur_div <= pending;
            end
            pend_valid <= 1'b0;
         end else if (load_ok) begin
            pending    <= div_val;
            pend_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable integer clock divider with glitch-free start/stop.
// clk_out is high for cur_div>>1 cycles of each cur_div-cycle period; tick marks each rise.
module prog_clock_divider
   import freq_div_pkg::*;
#(
   parameter int DIV_W     = 8,
   parameter int DIV_RESET = 6
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_val,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic [DIV_W-1:0] cur_div,
   output logic             div_err,
   output state_t           fsm_state
);

   // Handshake: en is a level request sampled every edge; div_load is a one-cycle
   // strobe qualifying div_val. There is no back-pressure on either input.

   state_t           state;
   state_t           next_state;
   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] count_d;
   logic [DIV_W-1:0] cnt_inc;
   logic [DIV_W-1:0] hi;
   logic [DIV_W-1:0] last;
   logic             wrap;
   logic             apply;
   logic             clk_out_d;
   logic             tick_d;

   assign hi      = cur_div >> 1;
   assign last    = cur_div - DIV_W'(1);
   assign cnt_inc = count + DIV_W'(1);
   assign wrap    = (state != IDLE) && (count == last);
   // IDLE applies loads immediately; running states only at the period boundary.
   assign apply   = (state == IDLE) || wrap;

   div_ratio_shadow #(
      .DIV_W     (DIV_W),
      .DIV_RESET (DIV_RESET)
   ) u_shadow (
      .clk      (clk),
      .rst      (rst),
      .div_load (div_load),
      .div_val  (div_val),
      .apply    (apply),
      .cur_div  (cur_div),
      .div_err  (div_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (en) next_state = RUN;
         RUN:     if (!en) next_state = DRAIN;
         DRAIN: begin
            if (en) begin
               next_state = RUN;
            end else if (wrap) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // A draining divider only stops at a wrap, so the final period is never cut short.
   always_comb begin
      count_d   = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               clk_out_d = 1'b1;
               tick_d    = 1'b1;
            end
         end
         RUN, DRAIN: begin
            if (wrap) begin
               if ((state == RUN) || en) begin
                  clk_out_d = 1'b1;
                  tick_d    = 1'b1;
               end
            end else begin
               count_d   = cnt_inc;
               clk_out_d = (cnt_inc < hi);
            end
         end
         default: begin
            count_d   = '0;
            clk_out_d = 1'b0;
            tick_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         count   <= count_d;
         clk_out <= clk_out_d;
         tick    <= tick_d;
      end
   end

   assign busy      = (state != IDLE);
   assign fsm_state = state;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: directed waveform checks plus
// randomized traffic compared every cycle against a period-level reference model.
module tb_prog_clock_divider;
   import freq_div_pkg::*;

   localparam int DIV_W     = 8;
   localparam int DIV_RESET = 6;
   localparam int EW        = DIV_W + 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             div_load = 1'b0;
   logic [DIV_W-1:0] div_val = '0;
   logic             clk_out;
   logic             tick;
   logic             busy;
   logic [DIV_W-1:0] cur_div;
   logic             div_err;
   state_t           fsm_state;

   int checks = 0;
   int errors = 0;

   prog_clock_divider #(
      .DIV_W     (DIV_W),
      .DIV_RESET (DIV_RESET)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .div_load  (div_load),
      .div_val   (div_val),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy),
      .cur_div   (cur_div),
      .div_err   (div_err),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks the position inside the current output period and the period length.
   bit  m_active = 1'b0;
   bit  m_drain  = 1'b0;
   bit  m_err    = 1'b0;
   int  m_pos    = 0;
   int  m_n      = DIV_RESET;
   int  m_pend   = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] e;

   function automatic logic [EW-1:0] m_pack();
      bit clk_o;
      bit tck;
      clk_o = m_active && (m_pos < m_n / 2);
      tck   = m_active && (m_pos == 0);
      return {clk_o, tck, m_active, m_err, DIV_W'(m_n)};
   endfunction

   task automatic model_step();
      int v;
      bit legal;
      v     = int'(div_val);
      legal = div_load && (v >= 2);
      m_err = div_load && (v < 2);
      if (!m_active) begin
         if (legal) m_n = v;
         m_pos = 0;
         if (en) begin
            m_active = 1'b1;
            m_drain  = 1'b0;
         end
      end else if (m_pos == m_n - 1) begin
         if (legal) m_n = v;
         else if (m_pend != 0) m_n = m_pend;
         m_pend = 0;
         if (m_drain && !en) m_active = 1'b0;
         m_pos   = 0;
         m_drain = !en;
      end else begin
         m_pos++;
         m_drain = !en;
         if (legal) m_pend = v;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_drain  = 1'b0;
         m_err    = 1'b0;
         m_pos    = 0;
         m_n      = DIV_RESET;
         m_pend   = 0;
      end else begin
         model_step();
      end
      exp_q.delete();
      exp_q.push_back(m_pack());
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("model_clk_out", 32'(clk_out), 32'(e[EW-1]));
         chk("model_tick",    32'(tick),    32'(e[EW-2]));
         chk("model_busy",    32'(busy),    32'(e[EW-3]));
         chk("model_div_err", 32'(div_err), 32'(e[EW-4]));
         chk("model_cur_div", 32'(cur_div), 32'(e[DIV_W-1:0]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wave(input string nm, input int n, input int start, input int cycles,
                       input bit err0);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         div_load = 1'b0;
         chk({nm, "_clk_out"}, 32'(clk_out), 32'(((start + i) % n) < (n / 2)));
         chk({nm, "_tick"},    32'(tick),    32'(((start + i) % n) == 0));
         chk({nm, "_busy"},    32'(busy),    32'(1));
         chk({nm, "_div_err"}, 32'(div_err), 32'((i == 0) ? err0 : 1'b0));
      end
   endtask

   task automatic stop_and_idle();
      en       = 1'b0;
      div_load = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("stop_idle_busy", 32'(busy), 32'(0));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_clk_out", 32'(clk_out), 32'(0));
      chk("rst_tick",    32'(tick),    32'(0));
      chk("rst_busy",    32'(busy),    32'(0));
      chk("rst_cur_div", 32'(cur_div), 32'(6));
      chk("rst_div_err", 32'(div_err), 32'(0));

      // default divisor 6: 3 high / 3 low, first tick one clock after en
      en = 1'b1;
      wave("t1", 6, 0, 12, 1'b0);
      chk("t1_cur_div", 32'(cur_div), 32'(6));
      stop_and_idle();

      // load in IDLE takes effect immediately
      div_load = 1'b1;
      div_val  = 8'd5;
      @(negedge clk);
      div_load = 1'b0;
      chk("t2_idle_cur_div", 32'(cur_div), 32'(5));
      chk("t2_idle_clk_out", 32'(clk_out), 32'(0));
      en = 1'b1;
      wave("t2", 5, 0, 10, 1'b0);
      // load on the wrap cycle applies at that wrap
      div_load = 1'b1;
      div_val  = 8'd2;
      wave("t2b", 2, 0, 8, 1'b0);
      chk("t2b_cur_div", 32'(cur_div), 32'(2));

      // mid-period load is deferred to the boundary
      div_load = 1'b1;
      div_val  = 8'd6;
      wave("t3a", 6, 0, 2, 1'b0);
      div_load = 1'b1;
      div_val  = 8'd4;
      wave("t3b", 6, 2, 4, 1'b0);
      chk("t3_cur_div_hold", 32'(cur_div), 32'(6));
      wave("t3c", 4, 0, 8, 1'b0);
      chk("t3_cur_div_new", 32'(cur_div), 32'(4));

      // illegal divisors rejected with a one-cycle error
      div_load = 1'b1;
      div_val  = 8'd6;
      wave("t4n", 6, 0, 6, 1'b0);
      div_load = 1'b1;
      div_val  = 8'd1;
      wave("t4a", 6, 0, 6, 1'b1);
      div_load = 1'b1;
      div_val  = 8'd0;
      wave("t4b", 6, 0, 6, 1'b1);
      chk("t4_cur_div", 32'(cur_div), 32'(6));

      // drop en mid-period: period completes then IDLE
      wave("t5a", 6, 0, 2, 1'b0);
      en = 1'b0;
      wave("t5b", 6, 2, 4, 1'b0);
      @(negedge clk);
      chk("t5_idle_clk_out", 32'(clk_out), 32'(0));
      chk("t5_idle_busy",    32'(busy),    32'(0));
      chk("t5_idle_tick",    32'(tick),    32'(0));
      // re-raise en during drain: no gap in the waveform
      en = 1'b1;
      wave("t5c", 6, 0, 2, 1'b0);
      en = 1'b0;
      wave("t5d", 6, 2, 2, 1'b0);
      en = 1'b1;
      wave("t5e", 6, 4, 14, 1'b0);

      // async reset in the high phase restores the default divisor at once
      div_load = 1'b1;
      div_val  = 8'd9;
      wave("t6a", 9, 0, 2, 1'b0);
      chk("t6_cur_div_9", 32'(cur_div), 32'(9));
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_clk_out", 32'(clk_out), 32'(0));
      chk("t6_rst_busy",    32'(busy),    32'(0));
      chk("t6_rst_tick",    32'(tick),    32'(0));
      chk("t6_rst_cur_div", 32'(cur_div), 32'(6));
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_post_cur_div", 32'(cur_div), 32'(6));
      chk("t6_post_busy",    32'(busy),    32'(0));

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 11) == 0) en = ~en;
         div_load = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 19) == 0) div_val = DIV_W'($urandom_range(13, 40));
         else                           div_val = DIV_W'($urandom_range(0, 12));
         if ($urandom_range(0, 699) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end

      stop_and_idle();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
